// File: rtl/store_axi_bridge.sv
// store_axi_bridge: buffers merged 32-bit stores and issues each as a single-beat AW/W write,
// tracking B responses. Define STORE_AXI_BRIDGE_ERR_CAPTURE_EN to record the first errored address.
module store_axi_bridge #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    output logic        in_ready,
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        idle,
    output logic        err_pulse,
    input  logic        err_clr,
    output logic [31:0] err_addr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;
    localparam entry_t ENTRY_ZERO = '{addr: 32'h0, data: 32'h0, strb: 4'h0};

    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   out_q, out_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic            err_pulse_q, err_pulse_d;
    logic            eligible_s, aw_fire_s, w_fire_s, push_s, pop_s, b_dec_s, b_err_s;

    assign in_ready  = (count_q != DEPTH_C);
    assign awvalid   = eligible_s && !aw_done_q;
    assign wvalid    = eligible_s && !w_done_q;
    assign awaddr    = mem_q[rd_ptr_q].addr;
    assign wdata     = mem_q[rd_ptr_q].data;
    assign wstrb     = mem_q[rd_ptr_q].strb;
    assign bready    = 1'b1;
    assign err_pulse = err_pulse_q;
    assign idle      = (count_q == {CW{1'b0}}) && (out_q == {OW{1'b0}}) && !aw_done_q && !w_done_q;

    // Next-state for store FIFO, channel handshake flags and outstanding-write count
    always_comb begin
        eligible_s = (count_q != {CW{1'b0}}) && (out_q < MAX_OUT_C);
        aw_fire_s  = eligible_s && !aw_done_q && awready;
        w_fire_s   = eligible_s && !w_done_q && wready;
        // The head retires once both channels have been accepted, in either order
        pop_s      = eligible_s && (aw_fire_s || aw_done_q) && (w_fire_s || w_done_q);
        push_s     = in_valid && (count_q != DEPTH_C);
        b_dec_s    = bvalid && (out_q != {OW{1'b0}});
        b_err_s    = bvalid && (bresp != 2'b00);

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = '{addr: in_addr, data: in_wdata, strb: in_wstrb};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            rd_ptr_d  = rd_ptr_q;
            aw_done_d = aw_done_q || aw_fire_s;
            w_done_d  = w_done_q || w_fire_s;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({pop_s, b_dec_s})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        err_pulse_d = b_err_s;
    end

    // Core state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_q       <= {OW{1'b0}};
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef STORE_AXI_BRIDGE_ERR_CAPTURE_EN
    localparam int AIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [AIW-1:0] AF_LAST_C = AIW'(MAX_OUTSTANDING - 1);

    logic [31:0]    af_q [MAX_OUTSTANDING];
    logic [31:0]    af_d [MAX_OUTSTANDING];
    logic [AIW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;
    logic [31:0]    err_addr_q, err_addr_d, match_s;
    logic           err_held_q, err_held_d;

    assign err_addr = err_addr_q;

    // In-flight address tracking mirrors the outstanding count; B retires the oldest entry
    always_comb begin
        af_d = af_q;
        if (pop_s) begin
            af_d[af_wr_q] = mem_q[rd_ptr_q].addr;
            af_wr_d       = (af_wr_q == AF_LAST_C) ? {AIW{1'b0}} : af_wr_q + AIW'(1);
        end else begin
            af_wr_d = af_wr_q;
        end

        // An underflowing B has no tracked address, so it reports 0
        if (b_dec_s) begin
            match_s = af_q[af_rd_q];
            af_rd_d = (af_rd_q == AF_LAST_C) ? {AIW{1'b0}} : af_rd_q + AIW'(1);
        end else begin
            match_s = 32'h0;
            af_rd_d = af_rd_q;
        end

        if (b_err_s && (!err_held_q || err_clr)) begin
            err_addr_d = match_s;
            err_held_d = 1'b1;
        end else if (err_clr) begin
            err_addr_d = 32'h0;
            err_held_d = 1'b0;
        end else begin
            err_addr_d = err_addr_q;
            err_held_d = err_held_q;
        end
    end

    // Error-capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                af_q[i] <= 32'h0;
            end
            af_wr_q    <= {AIW{1'b0}};
            af_rd_q    <= {AIW{1'b0}};
            err_addr_q <= 32'h0;
            err_held_q <= 1'b0;
        end else begin
            af_q       <= af_d;
            af_wr_q    <= af_wr_d;
            af_rd_q    <= af_rd_d;
            err_addr_q <= err_addr_d;
            err_held_q <= err_held_d;
        end
    end
`else
    logic unused_s;

    assign unused_s = err_clr;
    assign err_addr = 32'h0;
`endif

endmodule
